// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_sequencer
//  Purpose  : Arbitrates stack / MMR / fetch requests and drives a registered
//             address and route select to the memory demux; owns the stack pointer.
//  Revision : 1.0
// ============================================================================
module mem_access_sequencer #(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] SP_RESET   = 12'hFFF,
  parameter logic [ADDR_W-1:0] STACK_BASE = 12'hF00,
  parameter int                MEM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              mmr_req,
  input  logic [ADDR_W-1:0] mmr_addr,
  input  logic              push_req,
  input  logic              pop_req,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        sel,
  output logic              mem_en,
  output logic              fetch_gnt,
  output logic              mmr_gnt,
  output logic              stk_gnt,
  output logic [ADDR_W-1:0] sp,
  output logic              stk_ovf,
  output logic              stk_unf
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0]        SEL_FETCH = 2'd0;
  localparam logic [1:0]        SEL_MMR   = 2'd1;
  localparam logic [1:0]        SEL_STK   = 2'd2;
  localparam logic [1:0]        SEL_IDLE  = 2'd3;
  localparam logic [3:0]        CNT_LOAD  = 4'(MEM_LAT);
  localparam logic [ADDR_W-1:0] SP_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        sel_q, sel_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              fetch_gnt_q, fetch_gnt_d;
  logic              mmr_gnt_q, mmr_gnt_d;
  logic              stk_gnt_q, stk_gnt_d;

  // cnt is loaded with MEM_LAT so the grant lands in the cnt==0 cycle,
  // MEM_LAT+1 cycles after the request was seen in IDLE.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    mem_en_d    = mem_en_q;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    fetch_gnt_d = 1'b0;
    mmr_gnt_d   = 1'b0;
    stk_gnt_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A rejected stack op still holds its request during its grant cycle.
        if (!stk_gnt_q) begin
          if (push_req) begin
            if (sp_q < STACK_BASE) begin
              ovf_d     = 1'b1;
              stk_gnt_d = 1'b1;
            end else begin
              addr_d   = sp_q;
              sel_d    = SEL_STK;
              mem_en_d = 1'b1;
              sp_d     = sp_q - SP_ONE;
              cnt_d    = CNT_LOAD;
              state_d  = ST_ACCESS;
            end
          end else if (pop_req) begin
            if (sp_q == SP_RESET) begin
              unf_d     = 1'b1;
              stk_gnt_d = 1'b1;
            end else begin
              addr_d   = sp_q + SP_ONE;
              sel_d    = SEL_STK;
              mem_en_d = 1'b1;
              sp_d     = sp_q + SP_ONE;
              cnt_d    = CNT_LOAD;
              state_d  = ST_ACCESS;
            end
          end else if (mmr_req) begin
            addr_d   = mmr_addr;
            sel_d    = SEL_MMR;
            mem_en_d = 1'b1;
            cnt_d    = CNT_LOAD;
            state_d  = ST_ACCESS;
          end else if (fetch_req) begin
            addr_d   = fetch_addr;
            sel_d    = SEL_FETCH;
            mem_en_d = 1'b1;
            cnt_d    = CNT_LOAD;
            state_d  = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_IDLE;
          addr_d   = '0;
          sel_d    = SEL_IDLE;
          mem_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            case (sel_q)
              SEL_FETCH: fetch_gnt_d = 1'b1;
              SEL_MMR:   mmr_gnt_d   = 1'b1;
              default:   stk_gnt_d   = 1'b1;
            endcase
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        addr_d   = '0;
        sel_d    = SEL_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      sel_q       <= SEL_IDLE;
      mem_en_q    <= 1'b0;
      cnt_q       <= 4'd0;
      sp_q        <= SP_RESET;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      fetch_gnt_q <= 1'b0;
      mmr_gnt_q   <= 1'b0;
      stk_gnt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      mem_en_q    <= mem_en_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      fetch_gnt_q <= fetch_gnt_d;
      mmr_gnt_q   <= mmr_gnt_d;
      stk_gnt_q   <= stk_gnt_d;
    end
  end

  assign addr      = addr_q;
  assign sel       = sel_q;
  assign mem_en    = mem_en_q;
  assign fetch_gnt = fetch_gnt_q;
  assign mmr_gnt   = mmr_gnt_q;
  assign stk_gnt   = stk_gnt_q;
  assign sp        = sp_q;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule
`default_nettype wire
